// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and helpers for the parametrised receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per bit; integer division truncates, so the line rate rounds up slightly.
  function automatic int cnt_bps(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchronizer, falling-edge detect, bit-period divider and
// 3-sample majority vote around the bit centre.
module uart_rx_sampler #(
  parameter int CNT_BPS = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic run,
  output logic start_edge,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int HALF_BPS = CNT_BPS / 2;
  localparam int CW       = $clog2(CNT_BPS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_BPS - 1);
  localparam logic [CW-1:0] VOTE_0   = CW'(HALF_BPS - 1);
  localparam logic [CW-1:0] VOTE_1   = CW'(HALF_BPS);
  localparam logic [CW-1:0] VOTE_2   = CW'(HALF_BPS + 1);

  logic          sync1;
  logic          sync2;
  logic          hist;
  logic          vote0;
  logic          vote1;
  logic [CW-1:0] cnt_div;

  // All three line flops reset high so releasing reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_div <= '0;
    end else if (cnt_div == CNT_LAST) begin
      cnt_div <= '0;
    end else begin
      cnt_div <= cnt_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vote0 <= 1'b1;
      vote1 <= 1'b1;
    end else begin
      if (cnt_div == VOTE_0) vote0 <= sync2;
      if (cnt_div == VOTE_1) vote1 <= sync2;
    end
  end

  // The third sample is the live synced value, so the decision lands at HALF_BPS+1.
  assign start_edge = hist & ~sync2;
  assign bit_strobe = run && (cnt_div == VOTE_2);
  assign bit_val    = (vote0 & vote1) | (vote0 & sync2) | (vote1 & sync2);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority voting and a valid/ready output register.
// The parity state and checker are built only when UART_RX_PARITY_EN is defined.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_BPS = cnt_bps(CLK_FREQ, BAUD);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CNT_BPS < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_cfg_check
    $error("uart_rx_param: illegal parameter combination");
  end

  uart_state_t          state;
  uart_state_t          state_nxt;
  logic                 start_edge;
  logic                 bit_strobe;
  logic                 bit_val;
  logic                 shift_en;
  logic                 stop_chk;
  logic                 commit;
  logic                 load;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 ferr_pend;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ACTIVE = (PARITY_MODE != PAR_NONE);
  logic par_chk;
`endif

  uart_rx_sampler #(
    .CNT_BPS(CNT_BPS)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .run       (busy),
    .start_edge(start_edge),
    .bit_strobe(bit_strobe),
    .bit_val   (bit_val)
  );

  assign busy = (state != IDLE);
  assign load = commit && (!valid || ready);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    stop_chk  = 1'b0;
    commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (en && start_edge) state_nxt = START;
      end
      START: begin
        if (bit_strobe) begin
          if (bit_val) state_nxt = IDLE;
          else         state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
            if (PAR_ACTIVE) state_nxt = PARITY;
            else            state_nxt = STOP;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_strobe) begin
          par_chk   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        // Commit at the last stop-bit decision so a back-to-back start edge is not missed.
        if (bit_strobe) begin
          stop_chk = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en && state != IDLE) begin
      state_nxt = IDLE;
      shift_en  = 1'b0;
      stop_chk  = 1'b0;
      commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      ferr_pend <= 1'b0;
    end else if (state == IDLE) begin
      bit_cnt   <= '0;
      ferr_pend <= 1'b0;
    end else begin
      if (shift_en) begin
        shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
      end
      if (stop_chk) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (!bit_val) ferr_pend <= 1'b1;
      end
    end
  end

  // A word arriving while the held word is still unread is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        data      <= shift_reg;
        frame_err <= ferr_pend | ~bit_val;
        valid     <= 1'b1;
      end else if (commit) begin
        overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_pend;
  logic perr_q;
  logic par_exp;

  assign par_exp = (PARITY_MODE == PAR_ODD) ? ~(^shift_reg) : (^shift_reg);

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) perr_pend <= 1'b0;
    else if (par_chk)         perr_pend <= (bit_val != par_exp);
  end

  always_ff @(posedge clk) begin
    if (rst)       perr_q <= 1'b0;
    else if (load) perr_q <= perr_pend;
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
